capture_control: RTL and testbench
==================================

Name: capture_control

Overview:
- Sample-capture sequencer downstream of the trigger stage.
- Consumes trig_out, owns Enable_Trig, and generates sample-RAM write address and strobe.
- Sequence: fill a pre-trigger window, arm the trigger, write circularly until trigger, write a fixed post-trigger count, then stop and report the trigger address to the MCU interface.

Parameters:
- ADDR_W, 13, sample RAM address width; buffer depth is 2^ADDR_W samples.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- Start_Write  in  1  MCU run level. A rising edge starts a capture. Low aborts a capture in progress.
- CLK_EN  in  1  sample strobe; one sample per cycle with CLK_EN=1.
- Trig_IN  in  1  trig_out from the trigger stage.
- Force_Trig  in  1  MCU forced trigger.
- Pretrig_Len  in  ADDR_W  number of samples to write before arming.
- Post_Len  in  ADDR_W  number of samples to write after the trigger sample.
- WR_ADDR  out  ADDR_W  RAM write address.
- WR_EN  out  1  RAM write strobe.
- Enable_Trig  out  1  enable for the trigger stage.
- Trig_Addr  out  ADDR_W  address of the trigger sample.
- Busy  out  1  capture in progress.
- Done  out  1  capture complete.

Behaviour:
- Reset (nRST=0, asynchronous):
  - State IDLE.
  - All outputs 0; internal pointer ptr=0; counters 0; Start_Write edge register 0.
- Start edge detection: start_edge = Start_Write & ~Start_Write_d, where Start_Write_d is a registered copy.
- States: IDLE, PRE, ARMED, POST, DONE.
- Write path, registered, one-cycle latency:
  - On any edge where CLK_EN=1 and the state is PRE, ARMED or POST: WR_EN<=1, WR_ADDR<=ptr, ptr<=ptr+1.
  - ptr wraps modulo 2^ADDR_W (all-ones -> 0).
  - Otherwise WR_EN<=0 and WR_ADDR holds its value.
- IDLE / DONE, on start_edge:
  - ptr<=0, Done<=0, Busy<=1.
  - Latch Pretrig_Len and Post_Len into internal registers; later input changes are ignored.
  - If Pretrig_Len=0, go to ARMED with Enable_Trig<=1; else go to PRE with pre_cnt<=Pretrig_Len.
- PRE:
  - Each write decrements pre_cnt.
  - The write made with pre_cnt=1 is the last pre-trigger write: ARMED, Enable_Trig<=1 on the same edge.
  - Trig_IN and Force_Trig are ignored.
- ARMED:
  - Writes continue circularly with no limit.
  - Trigger condition: CLK_EN=1 & (Trig_IN | Force_Trig).
  - On trigger, the write of that same cycle is the trigger sample:
    - Trig_Addr<=ptr, Enable_Trig<=0.
    - If latched Post_Len=0, go to DONE; else go to POST with post_cnt<=Post_Len.
- POST:
  - Each write decrements post_cnt.
  - The write made with post_cnt=1 is the last write: DONE.
- DONE:
  - Busy<=0, Done<=1, no writes.
  - WR_ADDR and Trig_Addr hold their values.
  - Start_Write held high or falling has no effect; only a new rising edge restarts.
- Abort: Start_Write=0 while in PRE, ARMED or POST gives, on that edge:
  - State IDLE; Busy<=0, Enable_Trig<=0, Done stays 0.
  - No write occurs on that edge, even with CLK_EN=1.
- Priority on one edge: abort > state transition > write; a start_edge cannot coincide with an abort.
- Total samples written per capture: Pretrig_Len + (cycles spent in ARMED with CLK_EN) + Post_Len.
  - The ARMED count includes the trigger sample.
- CLK_EN=0 freezes all counters and ptr. Trig_IN is not sampled.
- Reset mid-capture returns to the reset state immediately; there is no recovery of a partial capture.

Test Plan:
- Reset, ADDR_W=4: assert nRST=0 mid-ARMED -> all outputs 0 without waiting for a CLK edge; state IDLE.
- Basic capture: Pretrig_Len=3, Post_Len=2, CLK_EN=1 continuously, Trig_IN pulsed 2 samples after arming -> expected response:
  - WR_ADDR sequence 0,1,2,3,4,5,6 with WR_EN high for 7 cycles.
  - Enable_Trig rises on the edge of write 2.
  - Trig_Addr=4; Done=1 after the write at addr 6; Busy=0.
- Wrap: ADDR_W=4, Pretrig_Len=15, trigger after 5 armed samples -> WR_ADDR wraps 15->0; Trig_Addr=4.
- Zero lengths: Pretrig_Len=0, Post_Len=0, Force_Trig=1 with the first CLK_EN -> exactly 1 write at addr 0, Trig_Addr=0, Done=1.
- Trigger suppression: Trig_IN=1 throughout PRE -> ignored; the trigger occurs on the first ARMED CLK_EN cycle.
- Abort and restart:
  - Start_Write falls in POST -> IDLE, Done=0, Enable_Trig=0, no further WR_EN.
  - Start_Write held high in DONE -> no restart.
  - New 0->1 edge -> ptr restarts at 0.
- CLK_EN gating: CLK_EN=1 one cycle in four -> one write per strobe; Trig_IN high on a non-strobe cycle is ignored.

Source files
------------

// File: rtl/capture_control.sv
// rtl/capture_control.sv - sample-capture sequencer: pre-trigger fill, armed circular write, post-trigger count
//
// Purpose: drives the sample-RAM write port and the trigger-stage enable for
// one capture per Start_Write rising edge, and reports where the trigger landed.
//
// Ports:
//   CLK          system clock
//   nRST         asynchronous active-low reset
//   Start_Write  MCU run level; rising edge starts, low aborts a running capture
//   CLK_EN       sample strobe, one sample per cycle with CLK_EN=1
//   Trig_IN      trigger from the trigger stage
//   Force_Trig   MCU forced trigger
//   Pretrig_Len  samples written before arming
//   Post_Len     samples written after the trigger sample
//   WR_ADDR      RAM write address (registered)
//   WR_EN        RAM write strobe (registered)
//   Enable_Trig  enable for the trigger stage
//   Trig_Addr    address of the trigger sample
//   Busy         capture in progress
//   Done         capture complete
module capture_control #(
  parameter int ADDR_W = 13
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              Start_Write,
  input  logic              CLK_EN,
  input  logic              Trig_IN,
  input  logic              Force_Trig,
  input  logic [ADDR_W-1:0] Pretrig_Len,
  input  logic [ADDR_W-1:0] Post_Len,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic              WR_EN,
  output logic              Enable_Trig,
  output logic [ADDR_W-1:0] Trig_Addr,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              start_d;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W-1:0] pre_cnt, pre_cnt_nxt;
  logic [ADDR_W-1:0] post_cnt, post_cnt_nxt;
  logic [ADDR_W-1:0] post_len_q, post_len_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt, trig_addr_nxt;
  logic              wr_en_nxt, en_trig_nxt, busy_nxt, done_nxt;

  logic start_edge;
  logic capturing;
  logic abort;
  logic do_write;

  assign start_edge = Start_Write & ~start_d;
  assign capturing  = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  // Abort wins over everything on the same edge, including the write.
  assign abort      = capturing & ~Start_Write;
  assign do_write   = capturing & Start_Write & CLK_EN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= S_IDLE;
      start_d     <= 1'b0;
      ptr         <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      post_len_q  <= '0;
      WR_ADDR     <= '0;
      WR_EN       <= 1'b0;
      Enable_Trig <= 1'b0;
      Trig_Addr   <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_d     <= Start_Write;
      ptr         <= ptr_nxt;
      pre_cnt     <= pre_cnt_nxt;
      post_cnt    <= post_cnt_nxt;
      post_len_q  <= post_len_nxt;
      WR_ADDR     <= wr_addr_nxt;
      WR_EN       <= wr_en_nxt;
      Enable_Trig <= en_trig_nxt;
      Trig_Addr   <= trig_addr_nxt;
      Busy        <= busy_nxt;
      Done        <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    pre_cnt_nxt   = pre_cnt;
    post_cnt_nxt  = post_cnt;
    post_len_nxt  = post_len_q;
    wr_addr_nxt   = WR_ADDR;
    wr_en_nxt     = 1'b0;
    trig_addr_nxt = Trig_Addr;
    en_trig_nxt   = Enable_Trig;
    busy_nxt      = Busy;
    done_nxt      = Done;

    if (abort) begin
      state_nxt   = S_IDLE;
      busy_nxt    = 1'b0;
      en_trig_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            ptr_nxt      = '0;
            done_nxt     = 1'b0;
            busy_nxt     = 1'b1;
            post_len_nxt = Post_Len;
            // Pretrig_Len is captured directly into the down-counter.
            if (Pretrig_Len == '0) begin
              state_nxt   = S_ARMED;
              en_trig_nxt = 1'b1;
            end else begin
              state_nxt   = S_PRE;
              pre_cnt_nxt = Pretrig_Len;
            end
          end
        end
        S_PRE: begin
          if (CLK_EN) begin
            pre_cnt_nxt = pre_cnt - 1'b1;
            if (pre_cnt == 1) begin
              state_nxt   = S_ARMED;
              en_trig_nxt = 1'b1;
            end
          end
        end
        S_ARMED: begin
          // The write made on the trigger cycle is the trigger sample itself.
          if (CLK_EN && (Trig_IN || Force_Trig)) begin
            trig_addr_nxt = ptr;
            en_trig_nxt   = 1'b0;
            if (post_len_q == '0) begin
              state_nxt = S_DONE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              state_nxt    = S_POST;
              post_cnt_nxt = post_len_q;
            end
          end
        end
        S_POST: begin
          if (CLK_EN) begin
            post_cnt_nxt = post_cnt - 1'b1;
            if (post_cnt == 1) begin
              state_nxt = S_DONE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    if (do_write) begin
      wr_en_nxt   = 1'b1;
      wr_addr_nxt = ptr;
      ptr_nxt     = ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_capture_control.sv
// tb/tb_capture_control.sv - self-checking bench for capture_control
module tb_capture_control;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          CLK;
  logic          nRST;
  logic          Start_Write;
  logic          CLK_EN;
  logic          Trig_IN;
  logic          Force_Trig;
  logic [AW-1:0] Pretrig_Len;
  logic [AW-1:0] Post_Len;
  logic [AW-1:0] WR_ADDR;
  logic          WR_EN;
  logic          Enable_Trig;
  logic [AW-1:0] Trig_Addr;
  logic          Busy;
  logic          Done;

  capture_control #(.ADDR_W(AW)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .Start_Write (Start_Write),
    .CLK_EN      (CLK_EN),
    .Trig_IN     (Trig_IN),
    .Force_Trig  (Force_Trig),
    .Pretrig_Len (Pretrig_Len),
    .Post_Len    (Post_Len),
    .WR_ADDR     (WR_ADDR),
    .WR_EN       (WR_EN),
    .Enable_Trig (Enable_Trig),
    .Trig_Addr   (Trig_Addr),
    .Busy        (Busy),
    .Done        (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a capture is described by how many samples it has written (m_n),
  // which sample index was the trigger (m_trig_n, -1 if none yet) and the
  // latched lengths. Addresses are simply the sample index modulo the depth.
  int            m_n, m_trig_n, m_pre, m_post;
  logic          m_busy, m_done, m_wr_en, m_sw_d;
  logic [AW-1:0] m_wr_addr, m_trig_addr;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_n = 0; m_trig_n = -1; m_pre = 0; m_post = 0;
      m_busy = 0; m_done = 0; m_wr_en = 0; m_sw_d = 0;
      m_wr_addr = '0; m_trig_addr = '0;
    end else begin
      m_wr_en = 0;
      if (m_busy && !Start_Write) begin
        m_busy = 0;
      end else if (m_busy && CLK_EN) begin
        m_wr_en   = 1;
        m_wr_addr = AW'(m_n % DEPTH);
        if (m_n >= m_pre && m_trig_n < 0 && (Trig_IN || Force_Trig)) begin
          m_trig_n    = m_n;
          m_trig_addr = m_wr_addr;
        end
        m_n++;
        if (m_trig_n >= 0 && m_n == m_trig_n + 1 + m_post) begin
          m_busy = 0;
          m_done = 1;
        end
      end else if (!m_busy && Start_Write && !m_sw_d) begin
        m_busy = 1; m_done = 0; m_n = 0; m_trig_n = -1;
        m_pre  = int'(Pretrig_Len);
        m_post = int'(Post_Len);
      end
      m_sw_d = Start_Write;
    end
  end

  function automatic int m_enable();
    return int'(m_busy && m_n >= m_pre && m_trig_n < 0);
  endfunction

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge CLK) begin
    chk("WR_EN", int'(WR_EN), int'(m_wr_en));
    chk("WR_ADDR", int'(WR_ADDR), int'(m_wr_addr));
    chk("Enable_Trig", int'(Enable_Trig), m_enable());
    chk("Trig_Addr", int'(Trig_Addr), int'(m_trig_addr));
    chk("Busy", int'(Busy), int'(m_busy));
    chk("Done", int'(Done), int'(m_done));
  end

  // Write log and the address on which Enable_Trig first rose with a write.
  int   wq[$];
  int   en_rise_addr;
  logic en_prev;
  initial en_prev = 1'b0;
  always @(negedge CLK) begin
    if (WR_EN) wq.push_back(int'(WR_ADDR));
    if (Enable_Trig && !en_prev && WR_EN) en_rise_addr = int'(WR_ADDR);
    en_prev = Enable_Trig;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic start(input int pre, input int post);
    Start_Write = 1'b0;
    cyc(1);
    Pretrig_Len  = AW'(pre);
    Post_Len     = AW'(post);
    Start_Write  = 1'b1;
    wq.delete();
    en_rise_addr = -1;
    cyc(1);
  endtask

  // Logged writes must be exactly n samples at consecutive addresses from 0.
  task automatic chk_seq(input string name, input int n);
    chk({name, "_count"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++)
      chk({name, "_addr"}, wq[i], i % DEPTH);
  endtask

  initial begin
    nRST = 0; Start_Write = 0; CLK_EN = 0; Trig_IN = 0; Force_Trig = 0;
    Pretrig_Len = '0; Post_Len = '0; en_rise_addr = -1;
    cyc(2);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_wr_en", int'(WR_EN), 0);
    chk("reset_enable", int'(Enable_Trig), 0);
    nRST = 1;
    cyc(2);

    // Basic: pre 3, post 2, trigger on the second armed sample.
    CLK_EN = 1;
    start(3, 2);
    cyc(4);
    Trig_IN = 1; cyc(1); Trig_IN = 0;
    cyc(4);
    chk_seq("basic", 7);
    chk("basic_trig_addr", int'(Trig_Addr), 4);
    chk("basic_done", int'(Done), 1);
    chk("basic_busy", int'(Busy), 0);
    chk("basic_enable_rise", en_rise_addr, 2);
    cyc(3);
    chk("done_hold_count", wq.size(), 7);
    chk("done_hold_done", int'(Done), 1);

    // Zero lengths with forced trigger on the first strobe.
    CLK_EN = 0; Force_Trig = 1;
    start(0, 0);
    CLK_EN = 1; cyc(1); Force_Trig = 0;
    cyc(3);
    chk_seq("zero", 1);
    chk("zero_trig_addr", int'(Trig_Addr), 0);
    chk("zero_done", int'(Done), 1);

    // Trig_IN held through PRE: fires on the first armed sample.
    Trig_IN = 1;
    start(5, 1);
    cyc(6); Trig_IN = 0;
    cyc(3);
    chk_seq("suppress", 7);
    chk("suppress_trig_addr", int'(Trig_Addr), 5);

    // Wrap: pre 15, five armed samples, trigger on the sixth.
    start(15, 2);
    cyc(20);
    Trig_IN = 1; cyc(1); Trig_IN = 0;
    cyc(4);
    chk_seq("wrap", 23);
    chk("wrap_trig_addr", int'(Trig_Addr), 4);

    // Abort in POST, then restart from address 0.
    start(2, 5);
    cyc(2);
    Trig_IN = 1; cyc(1); Trig_IN = 0;
    cyc(2);
    Start_Write = 0;
    cyc(4);
    chk_seq("abort", 5);
    chk("abort_done", int'(Done), 0);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_enable", int'(Enable_Trig), 0);
    Pretrig_Len = AW'(1); Post_Len = AW'(1);
    Start_Write = 1; wq.delete();
    cyc(2);
    Trig_IN = 1; cyc(1); Trig_IN = 0;
    cyc(3);
    chk_seq("restart", 3);
    chk("restart_trig_addr", int'(Trig_Addr), 1);
    chk("restart_done", int'(Done), 1);

    // Strobe one cycle in four; trigger on a non-strobe cycle is ignored.
    start(2, 1);
    for (int i = 0; i < 32; i++) begin
      CLK_EN  = (i % 4 == 0);
      Trig_IN = (i == 13) || (i == 20);
      cyc(1);
    end
    CLK_EN = 1; Trig_IN = 0;
    chk_seq("gated", 7);
    chk("gated_trig_addr", int'(Trig_Addr), 5);

    // Asynchronous reset while armed.
    start(1, 1);
    cyc(3);
    chk("pre_reset_busy", int'(Busy), 1);
    #2 nRST = 0;
    #1;
    chk("async_wr_addr", int'(WR_ADDR), 0);
    chk("async_wr_en", int'(WR_EN), 0);
    chk("async_enable", int'(Enable_Trig), 0);
    chk("async_trig_addr", int'(Trig_Addr), 0);
    chk("async_busy", int'(Busy), 0);
    chk("async_done", int'(Done), 0);
    Start_Write = 0;
    cyc(2);
    nRST = 1;
    cyc(3);
    chk("post_reset_busy", int'(Busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
